dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Execute-stage data-memory controller for the three-stage RISC-V pipeline. It consumes the E-stage memory controls (active-low chip select `cs_E`, write enable `wr_E`) plus address, store data and `funct3`. It runs a request/response handshake with the data memory and stalls the pipeline until the access completes. It returns byte-aligned, sign- or zero-extended load data to the write-back mux on the `wb_sel = 2'b01` path.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width (fixed 32 for byte-lane logic)
- `TIMEOUT`, 255, maximum cycles spent in REQ+RESP before abort

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-high
- `cs_E`  in  1  active-low access enable from the controller's E stage
- `wr_E`  in  1  1 = store, 0 = load; meaningful only when `cs_E = 0`
- `funct3_E`  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU; stores use only 000/001/010
- `addr_E`  in  AW  byte address (ALU result)
- `wdata_E`  in  DW  store data (rs2)
- `mem_req`  out  1  bus request, held until `mem_ready`
- `mem_we`  out  1  bus write
- `mem_addr`  out  AW  word address, `{addr[AW-1:2], 2'b00}`
- `mem_wdata`  out  DW  lane-replicated store data
- `mem_be`  out  4  byte enables
- `mem_ready`  in  1  request accepted
- `mem_rvalid`  in  1  read data valid
- `mem_rdata`  in  DW  read data
- `stall`  out  1  freeze the F/D and E stages
- `rdata`  out  DW  extended load result
- `misalign`  out  1  misaligned or illegal access, 1-cycle pulse
- `timeout`  out  1  bus timeout, 1-cycle pulse

## Operation
- FSM states: IDLE, REQ, RESP, DONE. All bus outputs, `rdata`, `misalign` and `timeout` are registered. `stall` is combinational.
- **IDLE**, `cs_E = 1`: no action; `stall = 0`.
- **IDLE**, `cs_E = 0`: latch `wr_E`, `funct3_E`, `addr_E` and `wdata_E`; assert `stall = 1`.
  - Illegal access goes straight to DONE with `misalign = 1` and no bus cycle. Illegal means: H/HU/SH with `addr[0] = 1`, W/SW with `addr[1:0] != 0`, load `funct3` in {011, 110, 111}, or store `funct3` > 010.
  - Otherwise go to REQ.
- **REQ**: `mem_req = 1`; address, `we`, `be` and `wdata` stay stable until `mem_ready`; `stall = 1`.
  - On `mem_ready`, a store goes to DONE.
  - On `mem_ready`, a load goes to RESP, or directly to DONE if `mem_rvalid` is also high in the same cycle.
  - `mem_req` drops on the clock edge after `mem_ready`.
- **RESP**: `stall = 1`; wait for `mem_rvalid`, capture and extend the data, then go to DONE.
- **DONE**: `stall = 0`, so the pipeline advances this cycle; next state is IDLE unconditionally. `cs_E` is ignored in DONE, which prevents re-issuing the held instruction.
- Timeout: a counter of width `$clog2(TIMEOUT+1)` clears on entry to REQ and increments each REQ/RESP cycle. On reaching `TIMEOUT`: drop `mem_req`, set `rdata = 0`, pulse `timeout` in DONE.
- Store lanes:
  - SB: `wdata = {4{b}}`, `be = 4'b0001 << addr[1:0]`
  - SH: `wdata = {2{h}}`, `be = 4'b0011 << {addr[1], 1'b0}`
  - SW: `be = 4'b1111`
- Load extract: select the byte at `addr[1:0]` or the halfword at `addr[1]`. B/H sign-extend; BU/HU zero-extend.
- `rdata` holds its value until the next load capture. A misaligned access or a timeout writes 0.
- E-stage inputs that change during REQ/RESP/DONE are ignored.

## Timing
- Reset: state IDLE; counter 0; `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`, `rdata`, `misalign`, `timeout` all 0. `stall` is 0 in the cycle after reset.
- Reset mid-transaction abandons the access; `mem_req` is 0 after the reset edge.
- Minimum store: cycle 0 IDLE (stall), cycle 1 REQ with ready, cycle 2 DONE. Access occupies 3 cycles, 2 of them stalled.
- Minimum load: same as the minimum store when `mem_rvalid` coincides with `mem_ready`. Each additional wait cycle adds one stall cycle.
- Misaligned access: 2 cycles (IDLE stall, DONE); `mem_req` never asserts.

## Structure
- Package `dmem_pkg` holds:
  - the state enum `dmem_state_t`
  - `funct3` localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`)
  - functions `store_be()` and `store_lanes()`
- One combinational sub-module, `load_align`: lane select plus sign/zero extension.

## Test plan
- SW `addr = 0x100`, `wdata = 0xDEADBEEF`, `mem_ready` in the first REQ cycle → `mem_addr = 0x100`, `be = 1111`; `stall` high for 2 cycles; DONE in cycle 2.
- LB `addr = 0x103`, `mem_rdata = 0x80FF_0000`, ready and rvalid together → `rdata = 0xFFFF_FF80`. Same access as LBU → `0x0000_0080`.
- SH `addr = 0x102`, `wdata = 0x1234_ABCD` → `mem_wdata = 0xABCD_ABCD`, `be = 1100`.
- LW `addr = 0x101` → no `mem_req`; `misalign` pulses in cycle 1; `rdata = 0`; `stall` high exactly 1 cycle.
- LW with `mem_ready` withheld for 5 cycles, then `rvalid` 2 cycles later → `mem_req` stable for 6 cycles; `stall` high until DONE; `rdata` captured.
- Load with `TIMEOUT = 4` and `mem_ready` never asserted → `timeout` pulse, `rdata = 0`, return to IDLE. A separate run asserts `reset` mid-REQ → all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the E-stage data-memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } dmem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_B:    store_be = 4'b0001 << a;
      F3_H:    store_be = 4'b0011 << {a[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      F3_B:    store_lanes = {4{d[7:0]}};
      F3_H:    store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  function automatic logic access_illegal(input logic we, input logic [2:0] f3,
                                          input logic [1:0] a);
    logic ill;
    if (we) ill = (f3 > F3_W);
    else    ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    if ((f3 == F3_H || f3 == F3_HU) && a[0]) ill = 1'b1;
    if (f3 == F3_W && a != 2'b00) ill = 1'b1;
    return ill;
  endfunction

endpackage

// File: rtl/dmem_ctrl_load_align.sv
// Load lane select with sign/zero extension of the returned bus word.
module load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    case (addr_lo_i)
      2'd0:    b = word_i[7:0];
      2'd1:    b = word_i[15:8];
      2'd2:    b = word_i[23:16];
      default: b = word_i[31:24];
    endcase
    h = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{b[7]}}, b};
      F3_H:    data_o = {{16{h[15]}}, h};
      F3_BU:   data_o = {24'd0, b};
      F3_HU:   data_o = {16'd0, h};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// E-stage data-memory controller: req/ready/rvalid handshake, pipeline stall,
// store lane replication and aligned, extended load return.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs_E,
  input  logic          wr_E,
  input  logic [2:0]    funct3_E,
  input  logic [AW-1:0] addr_E,
  input  logic [DW-1:0] wdata_E,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall,
  output logic [DW-1:0] rdata,
  output logic          misalign,
  output logic          timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  dmem_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    alo_q, alo_d;
  logic          req_q, req_d, mwe_q, mwe_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic [DW-1:0] mwdata_q, mwdata_d, rdata_q, rdata_d;
  logic [3:0]    be_q, be_d;
  logic          mis_q, mis_d, to_q, to_d;
  logic          illegal, expired;
  logic [31:0]   load_word;

  assign illegal = access_illegal(wr_E, funct3_E, addr_E[1:0]);
  // >= rather than == so a load entering RESP on the last REQ cycle still aborts
  assign expired = (cnt_q >= CW'(TIMEOUT - 1));

  load_align u_align (
    .word_i    (mem_rdata),
    .funct3_i  (f3_q),
    .addr_lo_i (alo_q),
    .data_o    (load_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      f3_q     <= '0;
      alo_q    <= '0;
      req_q    <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      mis_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      f3_q     <= f3_d;
      alo_q    <= alo_d;
      req_q    <= req_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      be_q     <= be_d;
      rdata_q  <= rdata_d;
      mis_q    <= mis_d;
      to_q     <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (!cs_E) state_d = illegal ? DONE : REQ;
      REQ: begin
        if (mem_ready)    state_d = (we_q || mem_rvalid) ? DONE : RESP;
        else if (expired) state_d = DONE;
      end
      RESP: if (mem_rvalid || expired) state_d = DONE;
      DONE: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall    = 1'b0;
    cnt_d    = cnt_q;
    we_d     = we_q;
    f3_d     = f3_q;
    alo_d    = alo_q;
    req_d    = req_q;
    mwe_d    = mwe_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    be_d     = be_q;
    rdata_d  = rdata_q;
    mis_d    = 1'b0;
    to_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!cs_E) begin
          stall = 1'b1;
          we_d  = wr_E;
          f3_d  = funct3_E;
          alo_d = addr_E[1:0];
          if (illegal) begin
            mis_d   = 1'b1;
            rdata_d = '0;
          end else begin
            cnt_d    = '0;
            req_d    = 1'b1;
            mwe_d    = wr_E;
            maddr_d  = {addr_E[AW-1:2], 2'b00};
            mwdata_d = wr_E ? store_lanes(funct3_E, wdata_E) : '0;
            be_d     = wr_E ? store_be(funct3_E, addr_E[1:0]) : 4'b1111;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (mem_ready) begin
          req_d = 1'b0;
          if (!we_q && mem_rvalid) rdata_d = load_word;
        end else if (expired) begin
          req_d   = 1'b0;
          rdata_d = '0;
          to_d    = 1'b1;
        end
      end
      RESP: begin
        stall = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (mem_rvalid) begin
          rdata_d = load_word;
        end else if (expired) begin
          rdata_d = '0;
          to_d    = 1'b1;
        end
      end
      DONE: ;
    endcase
  end

  assign mem_req   = req_q;
  assign mem_we    = mwe_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwdata_q;
  assign mem_be    = be_q;
  assign rdata     = rdata_q;
  assign misalign  = mis_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: main instance plus a short-timeout instance.
module tb_dmem_ctrl;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    int          done;
    int          stalls;
    int          reqs;
    bit          unstable;
    bus_t        bus;
    logic [31:0] rdata;
    logic        mis;
    logic        to;
    logic        post_mis;
    logic        post_to;
    logic        post_stall;
  } obs_t;

  logic clk, reset;
  logic cs_main, cs_to, wr_E;
  logic [2:0]  funct3_E;
  logic [31:0] addr_E, wdata_E;
  logic mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;

  logic m_req, m_we, m_stall, m_mis, m_to;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;
  logic t_req, t_we, t_stall, t_mis, t_to;
  logic [31:0] t_addr, t_wdata, t_rdata;
  logic [3:0]  t_be;

  logic sel_to;
  logic o_req, o_we, o_stall, o_mis, o_to;
  logic [31:0] o_addr, o_wdata, o_rdata;
  logic [3:0]  o_be;

  bus_t        bus_q[$];
  logic [31:0] rd_q[$];
  int total = 0;
  int bad   = 0;

  dmem_ctrl dut (
    .clk(clk), .reset(reset), .cs_E(cs_main), .wr_E(wr_E), .funct3_E(funct3_E),
    .addr_E(addr_E), .wdata_E(wdata_E), .mem_req(m_req), .mem_we(m_we),
    .mem_addr(m_addr), .mem_wdata(m_wdata), .mem_be(m_be), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .stall(m_stall),
    .rdata(m_rdata), .misalign(m_mis), .timeout(m_to)
  );

  dmem_ctrl #(.TIMEOUT(4)) dut_to (
    .clk(clk), .reset(reset), .cs_E(cs_to), .wr_E(wr_E), .funct3_E(funct3_E),
    .addr_E(addr_E), .wdata_E(wdata_E), .mem_req(t_req), .mem_we(t_we),
    .mem_addr(t_addr), .mem_wdata(t_wdata), .mem_be(t_be), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .stall(t_stall),
    .rdata(t_rdata), .misalign(t_mis), .timeout(t_to)
  );

  always_comb begin
    o_req   = sel_to ? t_req   : m_req;
    o_we    = sel_to ? t_we    : m_we;
    o_addr  = sel_to ? t_addr  : m_addr;
    o_wdata = sel_to ? t_wdata : m_wdata;
    o_be    = sel_to ? t_be    : m_be;
    o_stall = sel_to ? t_stall : m_stall;
    o_rdata = sel_to ? t_rdata : m_rdata;
    o_mis   = sel_to ? t_mis   : m_mis;
    o_to    = sel_to ? t_to    : m_to;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one access and acts as the memory; ready_wait < 0 never accepts.
  task automatic run_access(input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int ready_wait, input int rvalid_wait,
                            input logic [31:0] rword, output obs_t o);
    int   req_cnt, rv_cnt;
    bit   accepted, rv_done, have_first;
    bus_t first;
    o.done = -1; o.stalls = 0; o.reqs = 0; o.unstable = 0; o.bus = '0;
    o.rdata = '0; o.mis = 0; o.to = 0;
    req_cnt = 0; rv_cnt = 0; accepted = 0; rv_done = 0; have_first = 0; first = '0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (k == 0) begin
        if (sel_to) cs_to = 1'b0; else cs_main = 1'b0;
        wr_E = we; funct3_E = f3; addr_E = addr; wdata_E = wdata;
      end else begin
        wr_E = ~we; funct3_E = 3'b111; addr_E = ~addr; wdata_E = ~wdata;
      end
      if (o_req) begin
        o.reqs++;
        if (!have_first) begin
          first = {o_we, o_addr, o_be, o_wdata};
          have_first = 1;
        end else if (first !== {o_we, o_addr, o_be, o_wdata}) begin
          o.unstable = 1;
        end
      end
      if (o_req && !accepted) begin
        req_cnt++;
        if (ready_wait >= 0 && req_cnt > ready_wait) begin
          mem_ready = 1'b1; accepted = 1;
          o.bus = {o_we, o_addr, o_be, o_wdata};
          if (!we && rvalid_wait == 0) begin
            mem_rvalid = 1'b1; mem_rdata = rword; rv_done = 1;
          end
        end
      end else if (accepted && !we && !rv_done) begin
        rv_cnt++;
        if (rv_cnt >= rvalid_wait) begin
          mem_rvalid = 1'b1; mem_rdata = rword; rv_done = 1;
        end
      end
      #1;
      if (o_stall) o.stalls++;
      else if (k > 0) begin
        o.done = k; o.rdata = o_rdata; o.mis = o_mis; o.to = o_to;
        break;
      end
    end
    @(negedge clk);
    cs_main = 1'b1; cs_to = 1'b1; mem_ready = 1'b0; mem_rvalid = 1'b0;
    #1;
    o.post_mis = o_mis; o.post_to = o_to; o.post_stall = o_stall;
  endtask

  task automatic test_reset();
    reset = 1'b1; cs_main = 1'b1; cs_to = 1'b1; sel_to = 1'b0;
    wr_E = 1'b0; funct3_E = '0; addr_E = '0; wdata_E = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if ({m_req, m_we, m_stall, m_mis, m_to} !== 5'b0) begin
      bad++; $display("FAIL reset_ctl: got %b want 00000", {m_req, m_we, m_stall, m_mis, m_to});
    end
    total++;
    if ({m_addr, m_wdata, m_be, m_rdata} !== '0) begin
      bad++; $display("FAIL reset_data: got %h/%h/%b/%h want all zero", m_addr, m_wdata, m_be, m_rdata);
    end
    @(negedge clk); #1;
    total++;
    if (m_stall !== 1'b0 || t_stall !== 1'b0) begin
      bad++; $display("FAIL reset_stall: got %b/%b want 0/0", m_stall, t_stall);
    end
  endtask

  task automatic test_store_lanes();
    logic [2:0]  f3[5] = '{3'b010, 3'b001, 3'b001, 3'b000, 3'b000};
    logic [31:0] ad[5] = '{32'h100, 32'h102, 32'h100, 32'h101, 32'h103};
    logic [31:0] wd[5] = '{32'hDEADBEEF, 32'h1234ABCD, 32'h1234ABCD, 32'hCAFE005A, 32'hCAFE005A};
    logic [31:0] ew[5] = '{32'hDEADBEEF, 32'hABCDABCD, 32'hABCDABCD, 32'h5A5A5A5A, 32'h5A5A5A5A};
    logic [3:0]  eb[5] = '{4'b1111, 4'b1100, 4'b0011, 4'b0010, 4'b1000};
    obs_t o;
    bus_t e;
    sel_to = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_q.push_back({1'b1, ad[i] & 32'hFFFF_FFFC, eb[i], ew[i]});
      run_access(1'b1, f3[i], ad[i], wd[i], 0, 0, '0, o);
      e = bus_q.pop_front();
      total++;
      if (o.bus !== e) begin
        bad++; $display("FAIL store_bus[%0d]: got we=%b a=%h be=%b d=%h want we=%b a=%h be=%b d=%h",
                        i, o.bus.we, o.bus.addr, o.bus.be, o.bus.wdata, e.we, e.addr, e.be, e.wdata);
      end
      total++;
      if (o.done !== 2 || o.stalls !== 2 || o.reqs !== 1) begin
        bad++; $display("FAIL store_timing[%0d]: got done=%0d stalls=%0d reqs=%0d want 2/2/1",
                        i, o.done, o.stalls, o.reqs);
      end
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3[8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001, 3'b100, 3'b010};
    logic [31:0] ad[8] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h100, 32'h101, 32'h108};
    logic [31:0] rw[8] = '{32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h80FF0000,
                           32'h1234567F, 32'h12348001, 32'h0000C300, 32'hA5A50F0F};
    logic [31:0] ex[8] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF,
                           32'h0000007F, 32'hFFFF8001, 32'h000000C3, 32'hA5A50F0F};
    obs_t o;
    logic [31:0] er;
    bus_t e;
    sel_to = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_q.push_back(ex[i]);
      bus_q.push_back({1'b0, ad[i] & 32'hFFFF_FFFC, 4'b0, 32'b0});
      run_access(1'b0, f3[i], ad[i], 32'h0, 0, 0, rw[i], o);
      er = rd_q.pop_front();
      e  = bus_q.pop_front();
      total++;
      if (o.rdata !== er) begin
        bad++; $display("FAIL load_data[%0d]: got %h want %h", i, o.rdata, er);
      end
      total++;
      if (o.bus.we !== e.we || o.bus.addr !== e.addr || o.done !== 2 || o.stalls !== 2) begin
        bad++; $display("FAIL load_bus[%0d]: got we=%b a=%h done=%0d stalls=%0d want we=0 a=%h done=2 stalls=2",
                        i, o.bus.we, o.bus.addr, o.done, o.stalls, e.addr);
      end
    end
  endtask

  task automatic test_rdata_hold();
    obs_t o;
    logic [31:0] er;
    sel_to = 1'b0;
    rd_q.push_back(32'h0BADF00D);
    run_access(1'b0, 3'b010, 32'h10C, 32'h0, 0, 0, 32'h0BADF00D, o);
    run_access(1'b1, 3'b010, 32'h110, 32'h55555555, 0, 0, '0, o);
    er = rd_q.pop_front();
    total++;
    if (o.rdata !== er || o.post_stall !== 1'b0) begin
      bad++; $display("FAIL rdata_hold: got %h stall=%b want %h stall=0", o.rdata, o.post_stall, er);
    end
  endtask

  task automatic test_misalign();
    logic        we[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3[8] = '{3'b010, 3'b010, 3'b001, 3'b001, 3'b101, 3'b011, 3'b110, 3'b100};
    logic [31:0] ad[8] = '{32'h101, 32'h102, 32'h103, 32'h105, 32'h101, 32'h100, 32'h100, 32'h100};
    obs_t o;
    sel_to = 1'b0;
    for (int i = 0; i < 8; i++) begin
      run_access(we[i], f3[i], ad[i], 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, o);
      total++;
      if (o.done !== 1 || o.stalls !== 1 || o.reqs !== 0) begin
        bad++; $display("FAIL misalign_timing[%0d]: got done=%0d stalls=%0d reqs=%0d want 1/1/0",
                        i, o.done, o.stalls, o.reqs);
      end
      total++;
      if (o.mis !== 1'b1 || o.rdata !== 32'h0 || o.post_mis !== 1'b0) begin
        bad++; $display("FAIL misalign_flag[%0d]: got mis=%b rdata=%h post=%b want 1/0/0",
                        i, o.mis, o.rdata, o.post_mis);
      end
    end
  endtask

  task automatic test_wait_states();
    obs_t o;
    logic [31:0] er;
    sel_to = 1'b0;
    rd_q.push_back(32'h13579BDF);
    run_access(1'b0, 3'b010, 32'h104, 32'h0, 5, 2, 32'h13579BDF, o);
    er = rd_q.pop_front();
    total++;
    if (o.reqs !== 6 || o.unstable !== 1'b0) begin
      bad++; $display("FAIL wait_req: got reqs=%0d unstable=%b want 6/0", o.reqs, o.unstable);
    end
    total++;
    if (o.done !== 9 || o.stalls !== 9) begin
      bad++; $display("FAIL wait_stall: got done=%0d stalls=%0d want 9/9", o.done, o.stalls);
    end
    total++;
    if (o.rdata !== er || o.bus.addr !== 32'h104) begin
      bad++; $display("FAIL wait_data: got %h a=%h want %h a=00000104", o.rdata, o.bus.addr, er);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    logic [31:0] er;
    sel_to = 1'b1;
    rd_q.push_back(32'hCAFEF00D);
    run_access(1'b0, 3'b010, 32'h204, 32'h0, 0, 0, 32'hCAFEF00D, o);
    er = rd_q.pop_front();
    total++;
    if (o.rdata !== er) begin
      bad++; $display("FAIL to_preload: got %h want %h", o.rdata, er);
    end
    rd_q.push_back(32'h0);
    run_access(1'b0, 3'b010, 32'h200, 32'h0, -1, 0, 32'h0, o);
    er = rd_q.pop_front();
    total++;
    if (o.done !== 5 || o.stalls !== 5 || o.reqs !== 4) begin
      bad++; $display("FAIL to_timing: got done=%0d stalls=%0d reqs=%0d want 5/5/4",
                      o.done, o.stalls, o.reqs);
    end
    total++;
    if (o.to !== 1'b1 || o.rdata !== er || o.post_to !== 1'b0 || o.mis !== 1'b0) begin
      bad++; $display("FAIL to_flag: got to=%b rdata=%h post=%b mis=%b want 1/%h/0/0",
                      o.to, o.rdata, o.post_to, o.mis, er);
    end
    sel_to = 1'b0;
  endtask

  task automatic test_reset_mid();
    sel_to = 1'b0;
    @(negedge clk);
    cs_main = 1'b0; wr_E = 1'b1; funct3_E = 3'b001; addr_E = 32'h302; wdata_E = 32'h9999AAAA;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk); #1;
    total++;
    if (m_req !== 1'b1 || m_stall !== 1'b1) begin
      bad++; $display("FAIL rst_mid_req: got req=%b stall=%b want 1/1", m_req, m_stall);
    end
    reset = 1'b1; cs_main = 1'b1;
    @(negedge clk); #1;
    total++;
    if ({m_req, m_we, m_stall, m_mis, m_to} !== 5'b0 ||
        {m_addr, m_wdata, m_be, m_rdata} !== '0) begin
      bad++; $display("FAIL rst_mid_out: got ctl=%b a=%h d=%h be=%b r=%h want all zero",
                      {m_req, m_we, m_stall, m_mis, m_to}, m_addr, m_wdata, m_be, m_rdata);
    end
    reset = 1'b0;
    @(negedge clk); #1;
    total++;
    if (m_req !== 1'b0 || m_stall !== 1'b0) begin
      bad++; $display("FAIL rst_mid_idle: got req=%b stall=%b want 0/0", m_req, m_stall);
    end
  endtask

  initial begin
    test_reset();
    test_store_lanes();
    test_load_extend();
    test_rdata_hold();
    test_misalign();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
